// File: rtl/uart_rx_buf_pkg.sv
// uart_rx_buf_pkg: UART frame constants, receiver states and bit timing shared by the rx and tx paths
package uart_rx_buf_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
  localparam int data_bits = 8;
  localparam int stop_bits = 1;
  localparam logic start_level = 1'b0;
  localparam logic idle_level = 1'b1;
  typedef struct packed {
    int half;
    int bit_end;
  } bit_timing_t;
  function automatic bit_timing_t bit_timing(int cpb);
    return '{half: cpb / 2, bit_end: cpb - 1};
  endfunction
endpackage

// File: rtl/uart_rx_buf_sync_fifo.sv
// sync_fifo: show-ahead circular byte FIFO; a push while full is accepted only alongside a pop
module sync_fifo
  import uart_rx_buf_pkg::*;
#(
  parameter int fifo_log2 = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [data_bits-1:0] data_i,
  output logic [data_bits-1:0] data_o,
  output logic [fifo_log2:0]   count_o,
  output logic                 drop_o
);
  logic [data_bits-1:0] mem_q [2**fifo_log2];
  logic [fifo_log2-1:0] wr_q, rd_q;
  logic [fifo_log2:0] cnt_q;
  logic full, empty, do_push, do_pop;
  assign full = cnt_q[fifo_log2];
  assign empty = cnt_q == '0;
  assign do_pop = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);
  assign drop_o = push_i & full & ~do_pop;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (fifo_log2 + 1)'(do_push) - (fifo_log2 + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver with start/stop validation, sticky errors and a show-ahead receive FIFO
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int clocks_per_bit = 4,
  parameter int fifo_log2 = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_rx,
  input  logic                 in_rd,
  input  logic                 in_clear_err,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic [fifo_log2:0]   out_count,
  output logic                 out_frame_err,
  output logic                 out_overflow,
  output logic                 out_rx_busy
);
  localparam int cw = $clog2(clocks_per_bit);
  localparam bit_timing_t tm = bit_timing(clocks_per_bit);
  localparam logic [cw-1:0] half_m1 = cw'(tm.half - 1);
  localparam logic [cw-1:0] bit_m1 = cw'(tm.bit_end);
  rx_state_e state_q, state_d;
  logic s1_q, s2_q, rx_s, tick, push, frame_evt, drop;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic ferr_q, ferr_d, ovf_q, ovf_d;
  assign rx_s = s2_q;
  assign tick = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? bit_m1 : cnt_q - 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    push = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = half_m1;
        idx_d = '0;
        if (rx_s == start_level) state_d = START;
      end
      START: if (tick) state_d = (rx_s == start_level) ? DATA : IDLE;
      DATA: if (tick) begin
        sh_d = {rx_s, sh_q[7:1]};
        idx_d = idx_q + 1'b1;
        if (idx_q == 4'(data_bits - 1)) state_d = STOP;
      end
      STOP: if (tick) begin
        push = rx_s == idle_level;
        frame_evt = rx_s != idle_level;
        state_d = (rx_s == idle_level) ? IDLE : BREAK;
      end
      BREAK: if (rx_s == idle_level) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // a new error in the same cycle as a clear keeps the flag set
  assign ferr_d = frame_evt | (ferr_q & ~in_clear_err);
  assign ovf_d = drop | (ovf_q & ~in_clear_err);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      s1_q <= in_rx;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_d;
    end
  end
  sync_fifo #(.fifo_log2(fifo_log2)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .push_i(push),
    .pop_i(in_rd),
    .data_i(sh_q),
    .data_o(out_data),
    .count_o(out_count),
    .drop_o(drop)
  );
  assign out_valid = out_count != '0;
  assign out_frame_err = ferr_q;
  assign out_overflow = ovf_q;
  assign out_rx_busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: directed and randomized frames checked every cycle against a queue-based receiver model
module tb_uart_rx_buf;
  localparam int CPB = 4;
  localparam int HALF = CPB / 2;
  localparam int DEPTH = 16;
  typedef struct {
    int at;
    logic [7:0] d;
    logic good;
  } ev_t;
  logic clk = 1'b0, resetn, in_rx, in_rd, in_clear_err;
  logic rd_req, clr_req, rnd_rd = 1'b0, rnd_clr = 1'b0, rnd_en, chk_en = 1'b0;
  logic [7:0] out_data;
  logic [4:0] out_count;
  logic out_valid, out_frame_err, out_overflow, out_rx_busy;
  int tests = 0, fails = 0, cyc = 0, pidx = 0, rd_pct = 0;
  ev_t pend[$];
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic m_ferr = 1'b0, m_ovf = 1'b0, m_pu, m_bad, m_drop;
  logic [7:0] m_d;
  assign in_rd = rd_req | rnd_rd;
  assign in_clear_err = clr_req | rnd_clr;
  always #5 clk = ~clk;
  uart_rx_buf #(.clocks_per_bit(CPB), .fifo_log2(4)) dut (
    .clk(clk), .resetn(resetn), .in_rx(in_rx), .in_rd(in_rd), .in_clear_err(in_clear_err),
    .out_data(out_data), .out_valid(out_valid), .out_count(out_count),
    .out_frame_err(out_frame_err), .out_overflow(out_overflow), .out_rx_busy(out_rx_busy)
  );
  // model: each frame completes on a precomputed edge; FIFO is a plain queue capped at DEPTH
  always @(posedge clk) begin
    cyc = cyc + 1;
    m_pu = 1'b0;
    m_bad = 1'b0;
    if (pidx < pend.size() && pend[pidx].at == cyc) begin
      m_pu = pend[pidx].good;
      m_bad = !pend[pidx].good;
      m_d = pend[pidx].d;
      pidx++;
    end
    if (!resetn) begin
      mq.delete();
      m_ferr = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (in_rd && mq.size() != 0) void'(mq.pop_front());
      m_drop = m_pu && mq.size() == DEPTH;
      if (m_pu && !m_drop) mq.push_back(m_d);
      m_ferr = m_bad || (m_ferr && !in_clear_err);
      m_ovf = m_drop || (m_ovf && !in_clear_err);
    end
  end
  always @(negedge clk) begin
    rnd_rd = rnd_en && ($urandom_range(0, 99) < rd_pct);
    rnd_clr = rnd_en && ($urandom_range(0, 49) == 0);
  end
  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 25) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        // the start level is first sampled on the next edge; the stop sample lands 2+HALF+9*CPB edges later
        if (s == 0 && k == 0) pend.push_back('{at: cyc + 1 + 2 + HALF + 9 * CPB, d: d, good: stop});
        in_rx = f[s];
      end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_rx = 1'b1;
    end
  endtask
  task automatic pop_all(input string nm);
    while (exp_q.size() != 0) begin
      chk(nm, out_data, exp_q.pop_front());
      rd_req = 1'b1;
      @(negedge clk);
    end
    rd_req = 1'b0;
    chk({nm, "_empty"}, out_valid, 0);
  endtask
  initial begin
    resetn = 1'b0;
    in_rx = 1'b1;
    rd_req = 1'b0;
    clr_req = 1'b0;
    rnd_en = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("valid", out_valid, mq.size() != 0);
          chk("count", out_count, mq.size());
          if (mq.size() != 0) chk("data", out_data, mq[0]);
          chk("frame_err", out_frame_err, m_ferr);
          chk("overflow", out_overflow, m_ovf);
        end
      end
    join_none
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ferr", out_frame_err, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_busy", out_rx_busy, 0);
    resetn = 1'b1;
    chk_en = 1'b1;
    idle(4);
    // single byte: valid appears one cycle after the stop sample
    send_frame(8'hA5, 1'b1);
    @(negedge clk);
    chk("a5_early_valid", out_valid, 0);
    @(negedge clk);
    chk("a5_valid", out_valid, 1);
    chk("a5_data", out_data, 8'hA5);
    chk("a5_count", out_count, 1);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk("a5_pop_valid", out_valid, 0);
    chk("a5_pop_count", out_count, 0);
    idle(4);
    // one-cycle glitch
    @(negedge clk);
    in_rx = 1'b0;
    @(negedge clk);
    in_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy", out_rx_busy, 1);
    @(negedge clk);
    chk("glitch_idle", out_rx_busy, 0);
    idle(6);
    // bad stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0);
    repeat (40) begin
      @(negedge clk);
      in_rx = 1'b0;
    end
    chk("break_busy", out_rx_busy, 1);
    chk("break_ferr", out_frame_err, 1);
    chk("break_count", out_count, 0);
    idle(8);
    chk("break_exit", out_rx_busy, 0);
    send_frame(8'h55, 1'b1);
    repeat (2) @(negedge clk);
    chk("after_break_data", out_data, 8'h55);
    chk("after_break_ferr", out_frame_err, 1);
    rd_req = 1'b1;
    clr_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    clr_req = 1'b0;
    chk("ferr_cleared", out_frame_err, 0);
    idle(4);
    // 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    repeat (2) @(negedge clk);
    chk("ovf_count", out_count, 16);
    chk("ovf_flag", out_overflow, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    pop_all("ovf_pop");
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    chk("ovf_cleared", out_overflow, 0);
    // push and pop on the same edge while full
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
    send_frame(8'h77, 1'b1);
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk("full_pp_count", out_count, 16);
    chk("full_pp_ovf", out_overflow, 0);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'h20 + 8'(i));
    exp_q.push_back(8'h77);
    pop_all("full_pp_pop");
    // reset in the middle of a frame with bytes queued
    for (int i = 0; i < 3; i++) send_frame(8'hB1 + 8'(i), 1'b1);
    repeat (4) begin
      @(negedge clk);
      in_rx = 1'b0;
    end
    for (int b = 0; b < 3; b++)
      repeat (CPB) begin
        @(negedge clk);
        in_rx = ~b[0];
      end
    chk("mid_busy", out_rx_busy, 1);
    chk("mid_count", out_count, 3);
    @(negedge clk);
    resetn = 1'b0;
    in_rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", out_rx_busy, 0);
    chk("mid_rst_flags", {out_frame_err, out_overflow}, 0);
    resetn = 1'b1;
    idle(4);
    send_frame(8'hE1, 1'b1);
    repeat (2) @(negedge clk);
    chk("e1_data", out_data, 8'hE1);
    chk("e1_count", out_count, 1);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    // randomized traffic: good, bad-stop and glitch events with random reads and clears
    rnd_en = 1'b1;
    for (int n = 0; n < 140; n++) begin
      int r;
      rd_pct = n < 70 ? 2 : 35;
      r = $urandom_range(0, 99);
      if (r < 10) begin
        send_frame(8'($urandom), 1'b0);
        idle($urandom_range(4, 10));
      end else if (r < 15) begin
        @(negedge clk);
        in_rx = 1'b0;
        idle($urandom_range(4, 8));
      end else begin
        send_frame(8'($urandom), 1'b1);
        idle($urandom_range(0, 6));
      end
    end
    rnd_en = 1'b0;
    idle(60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_buf.md
Name: uart_rx_buf

Overview:
- 8N1 UART receiver with an on-chip receive FIFO. It is the far end of the link driven by the team's buffered UART transmitter.
- Samples the serial line with a fixed integer clocks-per-bit timebase and validates start and stop bits.
- Pushes good bytes into a show-ahead FIFO that is drained with a valid/read handshake.
- Sits between the board RX pin and any byte consumer (debug console, loader).

Parameters:
- clocks_per_bit, 4, clk cycles per serial bit. Must match the transmitter. Minimum 2.
- fifo_log2, 4, log2 of FIFO depth (default depth 16).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- in_rx  in  1  asynchronous serial line, idle high.
- in_rd  in  1  pop request. Honoured only when out_valid=1.
- in_clear_err  in  1  clears both sticky error flags.
- out_data  out  8  FIFO head byte. Valid when out_valid=1.
- out_valid  out  1  FIFO non-empty.
- out_count  out  fifo_log2+1  current FIFO occupancy, 0..depth.
- out_frame_err  out  1  sticky: a byte was received with stop bit = 0.
- out_overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- out_rx_busy  out  1  receiver state is not IDLE.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, both synchronizer flops=1, FIFO pointers and count=0.
  - out_valid=0, out_count=0, out_frame_err=0, out_overflow=0, out_rx_busy=0, out_data=don't-care.
  - Reset mid-frame abandons the frame. The FIFO is emptied.
- Synchronizer: two flops take in_rx to rx_s, giving 2 cycles latency. All sampling uses rx_s.
- Timebase: cycle counter of width $clog2(clocks_per_bit), and a 4-bit bit index. half = clocks_per_bit/2, rounded down.
- States:
  - IDLE: when rx_s=0, go to START and load counter so the start-bit sample lands at t0+half, where t0 is the first cycle rx_s=0.
  - START: sample rx_s at t0+half. If 1 (glitch), return to IDLE with no error. If 0, go to DATA.
  - DATA: sample bit i (LSB first, i=0..7) at t0+half+(i+1)*clocks_per_bit, shifting into an 8-bit shift register.
  - STOP: sample at t0+half+9*clocks_per_bit.
    - Stop=1: push the byte, go to IDLE.
    - Stop=0: set out_frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line (break) from retriggering frames.
- Back-to-back frames: IDLE is re-entered at the stop-sample cycle. A start edge arriving half a bit after the stop sample is caught with no lost frames.
- Push timing: the byte is written on the stop-sample edge. out_valid and out_count reflect it on the next cycle.
- FIFO:
  - Circular buffer of depth 2^fifo_log2 with pointers of width fifo_log2 that wrap naturally.
  - Count has width fifo_log2+1 so that full and empty are distinguishable.
  - out_data = mem[rd_ptr], combinational read (show-ahead).
  - Pop when in_rd & out_valid. in_rd while empty is ignored.
- Simultaneous push and pop:
  - Always accepted, including when full. Count is unchanged and the head advances.
  - A push while full with no pop drops the byte and sets out_overflow. FIFO contents are unchanged.
- Errors:
  - Sticky until in_clear_err=1.
  - If in_clear_err and a new error event occur in the same cycle, set wins.
  - Errors never block reception.

Decomposition:
- Shared uart package:
  - rx state enum (IDLE, START, DATA, STOP, BREAK).
  - Frame constants: data bits 8, stop bits 1, start level 0, idle level 1.
  - A function computing half-bit and bit-end counts from clocks_per_bit.
- One natural sub-module: sync_fifo (parameter fifo_log2, 8-bit width, push, pop, count, show-ahead head). It is reusable by the transmit path.

Test Plan:
All scenarios use clocks_per_bit=4 and depth 16.
1. Send 0xA5 (line: 0, then 1,0,1,0,0,1,0,1 LSB first, then 1). Expect out_valid=1 at t0+39, out_data=0xA5, out_count=1. in_rd for one cycle gives out_valid=0 and out_count=0.
2. Pulse in_rx low for 1 cycle (glitch), then return to idle. Expect no push, out_rx_busy drops after the start sample, no error.
3. Send 0x3C with stop bit 0, then hold the line low for 40 cycles. Expect out_frame_err=1, out_count=0, state stays BREAK until the line goes high. A following 0x55 is received correctly.
4. Send 17 bytes 0x00..0x10 back-to-back with no reads. Expect out_count=16, out_overflow=1, and the 16 pops return 0x00..0x0F in order. in_clear_err then sets out_overflow=0.
5. Fill to 16, then hold in_rd=1 while byte 0x77 completes. Expect no overflow, count stays 16, and 0x77 is last in the pop sequence.
6. Assert resetn=0 mid-DATA with 3 bytes queued. Expect out_count=0, out_valid=0, flags=0. The next full frame 0xE1 is received correctly.
